ycbcr_mask_bbox: RTL
====================

Name: ycbcr_mask_bbox

Overview:
Stage directly downstream of the RGB->YCbCr converter. It consumes the converter's {Y,Cb,Cr} video stream and classifies each active pixel against a Cb/Cr window, producing a binary skin mask. It accumulates a per-frame bounding box and pixel count of the mask, and draws the previous frame's box in red over the mask. Syncs and DE are delayed so they stay aligned with the output pixel, so the stage drops into the video chain before the RGB output path.

Parameters:
CB_MIN, 77, inclusive lower Cb bound
CB_MAX, 127, inclusive upper Cb bound
CR_MIN, 133, inclusive lower Cr bound
CR_MAX, 173, inclusive upper Cr bound
COORD_W, 11, width of x/y counters and box coordinates
CNT_W, 21, width of the mask pixel counter
MIN_PIX, 64, minimum mask pixels per frame for the box to be valid

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
de_in  in  1  data enable from the converter
hsync_in  in  1  hsync from the converter
vsync_in  in  1  vsync from the converter, active high
pixel_in  in  24  {Y[23:16], Cb[15:8], Cr[7:0]}
de_out  out  1  de_in delayed 2 cycles
hsync_out  out  1  hsync_in delayed 2 cycles
vsync_out  out  1  vsync_in delayed 2 cycles
pixel_out  out  24  RGB888: mask, or overlay colour
bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax  out  COORD_W each  latched box of the last completed frame
bbox_count  out  CNT_W  mask pixel count of the last completed frame
bbox_valid  out  1  latched box is valid

Behaviour:
- Clock is clk; reset is asynchronous and active-low (rst_n); all flops clear on rst_n=0 regardless of clk.
- Reset values: de/hsync/vsync_out=0, pixel_out=0, bbox_* coords=0, bbox_count=0, bbox_valid=0, x=y=0, accumulators at their initial values.
- Latency is exactly 2 cycles, pixel_in to pixel_out, with all three syncs delayed identically.
- Stage 1 (registered):
  - mask = de_in & (CB_MIN<=Cb<=CB_MAX) & (CR_MIN<=Cr<=CR_MAX), comparisons unsigned 8-bit.
  - The stage also registers the current pixel's x,y.
- Coordinates:
  - x increments on each de_in=1 cycle and clears on the falling edge of de (de_in=0 with de_d=1).
  - y increments on each de falling edge.
  - x and y both clear on the frame boundary.
  - Both saturate at 2^COORD_W-1 and never wrap.
- Frame boundary = rising edge of vsync_in (vsync_in=1, vsync_d=0).
- On the boundary cycle:
  - bbox_count is loaded with the accumulated count.
  - bbox_valid is set to (count>=MIN_PIX).
  - If valid, the four accumulated coords are loaded into bbox_*; if invalid, the previous bbox_* coords are held.
  - Accumulators reset: xmin=ymin=all-ones, xmax=ymax=0, count=0.
- Accumulation: each mask=1 pixel updates min/max x/y and increments count, which saturates at 2^CNT_W-1.
- A pixel with de_in=1 in the boundary cycle belongs to the new frame. It is accumulated into the freshly reset accumulators at coordinate (0,0).
- Stage 2 output colour, chosen in this priority order:
  - de=0 -> 0x000000.
  - bbox_valid and pixel on the box perimeter -> 0xFF0000. Perimeter means (x==xmin or x==xmax) with ymin<=y<=ymax, or (y==ymin or y==ymax) with xmin<=x<=xmax.
  - mask=1 -> 0xFFFFFF.
  - Otherwise -> 0x000000.
- The overlay uses the bbox registers as they stand in the stage-2 cycle. An update on the boundary applies from the next pixel on.
- Reset asserted mid-frame discards all accumulators and the latched box. The first boundary after reset release yields a box only from pixels seen since release.

Decomposition:
- Shared package ycbcr_pkg holds:
  - byte-field offsets for Y/Cb/Cr within the 24-bit word;
  - colour constants COL_BLACK, COL_WHITE, COL_RED;
  - default threshold constants, reused by the converter testbench.
- One sub-module, bbox_accum, holds the min/max/count accumulators, the boundary latch and MIN_PIX validation. The top level holds the compare, counters, delay pipeline and overlay.

Test Plan:
- Reset then constant pixel_in={Y=0x80,Cb=100,Cr=150} with de=1 -> after 2 cycles pixel_out=0xFFFFFF, de_out=1; with Cb=50 -> 0x000000.
- Boundary thresholds: Cb=77/127 and Cr=133/173 -> white; Cb=76, Cb=128, Cr=132, Cr=174 -> black.
- 64x48 frame with a skin block at x=10..19, y=5..14 (100 px), then vsync rise -> bbox=(10,19,5,14), count=100, valid=1. The next frame shows 0xFF0000 on that perimeter only.
- Frame with 10 skin pixels (<MIN_PIX) -> bbox_valid=0, bbox_count=10, coords held from the prior frame, no red drawn.
- Assert rst_n=0 for 1 cycle mid-line, asynchronously between clk edges -> all outputs 0 immediately. The next frame's box reflects only post-reset pixels.
- Skin pixel with de_in=1 on the vsync rising cycle -> counted in the new frame at (0,0), not in the latched count.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// Shared constants for the YCbCr video stages: field offsets inside the 24-bit
// pixel word, overlay colours and the default skin-tone Cb/Cr window.
package ycbcr_pkg;

    localparam int PIX_W  = 24;
    localparam int Y_OFS  = 16;
    localparam int CB_OFS = 8;
    localparam int CR_OFS = 0;

    localparam logic [PIX_W-1:0] COL_BLACK = 24'h000000;
    localparam logic [PIX_W-1:0] COL_WHITE = 24'hFFFFFF;
    localparam logic [PIX_W-1:0] COL_RED   = 24'hFF0000;

    localparam logic [7:0] CB_MIN_DEF = 8'd77;
    localparam logic [7:0] CB_MAX_DEF = 8'd127;
    localparam logic [7:0] CR_MIN_DEF = 8'd133;
    localparam logic [7:0] CR_MAX_DEF = 8'd173;

    function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/ycbcr_mask_bbox_if.sv
// Video stream bundle around the mask/bbox stage: converter-side input and
// the delayed, recoloured output toward the RGB path.
interface ycbcr_mask_bbox_if;
    import ycbcr_pkg::*;

    logic             de_in;
    logic             hsync_in;
    logic             vsync_in;
    logic [PIX_W-1:0] pixel_in;
    logic             de_out;
    logic             hsync_out;
    logic             vsync_out;
    logic [PIX_W-1:0] pixel_out;

    modport master (
        output de_in, hsync_in, vsync_in, pixel_in,
        input  de_out, hsync_out, vsync_out, pixel_out
    );

    modport slave (
        input  de_in, hsync_in, vsync_in, pixel_in,
        output de_out, hsync_out, vsync_out, pixel_out
    );

endinterface

// File: rtl/ycbcr_mask_bbox_accum.sv
// Per-frame mask statistics: running min/max/count, latched into the visible
// box at each frame boundary when enough mask pixels were seen.
module bbox_accum #(
    parameter int COORD_W = 11,
    parameter int CNT_W   = 21,
    parameter int MIN_PIX = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_boundary,
    input  logic               i_mask,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic [COORD_W-1:0] o_xmin,
    output logic [COORD_W-1:0] o_xmax,
    output logic [COORD_W-1:0] o_ymin,
    output logic [COORD_W-1:0] o_ymax,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_valid
);

    localparam logic [COORD_W-1:0] COORD_ONES = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    logic [COORD_W-1:0] r_acc_xmin, r_acc_xmax, r_acc_ymin, r_acc_ymax;
    logic [CNT_W-1:0]   r_acc_cnt;
    logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [CNT_W-1:0]   r_count;
    logic               r_valid;
    logic               w_enough;

    assign w_enough = (r_acc_cnt >= CNT_W'(MIN_PIX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_xmin <= COORD_ONES;
            r_acc_xmax <= '0;
            r_acc_ymin <= COORD_ONES;
            r_acc_ymax <= '0;
            r_acc_cnt  <= '0;
            r_xmin     <= '0;
            r_xmax     <= '0;
            r_ymin     <= '0;
            r_ymax     <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
        end else if (i_boundary) begin
            r_count <= r_acc_cnt;
            r_valid <= w_enough;
            if (w_enough) begin
                r_xmin <= r_acc_xmin;
                r_xmax <= r_acc_xmax;
                r_ymin <= r_acc_ymin;
                r_ymax <= r_acc_ymax;
            end
            // A mask pixel on the boundary cycle opens the new frame's statistics.
            if (i_mask) begin
                r_acc_xmin <= i_x;
                r_acc_xmax <= i_x;
                r_acc_ymin <= i_y;
                r_acc_ymax <= i_y;
                r_acc_cnt  <= CNT_W'(1);
            end else begin
                r_acc_xmin <= COORD_ONES;
                r_acc_xmax <= '0;
                r_acc_ymin <= COORD_ONES;
                r_acc_ymax <= '0;
                r_acc_cnt  <= '0;
            end
        end else if (i_mask) begin
            if (i_x < r_acc_xmin) r_acc_xmin <= i_x;
            if (i_x > r_acc_xmax) r_acc_xmax <= i_x;
            if (i_y < r_acc_ymin) r_acc_ymin <= i_y;
            if (i_y > r_acc_ymax) r_acc_ymax <= i_y;
            if (r_acc_cnt != CNT_MAX) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
        end
    end

    assign o_xmin  = r_xmin;
    assign o_xmax  = r_xmax;
    assign o_ymin  = r_ymin;
    assign o_ymax  = r_ymax;
    assign o_count = r_count;
    assign o_valid = r_valid;

endmodule

// File: rtl/ycbcr_mask_bbox.sv
// Skin-mask classifier with per-frame bounding box; draws the previous frame's
// box in red over the binary mask with a fixed two-cycle latency.
module ycbcr_mask_bbox
    import ycbcr_pkg::*;
#(
    parameter logic [7:0] CB_MIN  = CB_MIN_DEF,
    parameter logic [7:0] CB_MAX  = CB_MAX_DEF,
    parameter logic [7:0] CR_MIN  = CR_MIN_DEF,
    parameter logic [7:0] CR_MAX  = CR_MAX_DEF,
    parameter int         COORD_W = 11,
    parameter int         CNT_W   = 21,
    parameter int         MIN_PIX = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    ycbcr_mask_bbox_if.slave   vid,
    output logic [COORD_W-1:0] bbox_xmin,
    output logic [COORD_W-1:0] bbox_xmax,
    output logic [COORD_W-1:0] bbox_ymin,
    output logic [COORD_W-1:0] bbox_ymax,
    output logic [CNT_W-1:0]   bbox_count,
    output logic               bbox_valid
);

    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    logic [7:0]         w_cb, w_cr;
    logic               w_unused_y;
    logic               w_mask, w_boundary, w_de_fall;
    logic [COORD_W-1:0] w_x, w_y, w_x_inc, w_y_inc;
    logic [COORD_W-1:0] r_x, r_y;
    logic               r_de1, r_hs1, r_vs1, r_mask1;
    logic [COORD_W-1:0] r_x1, r_y1;
    logic               r_de2, r_hs2, r_vs2;
    logic [PIX_W-1:0]   r_pix2;
    logic               w_in_x, w_in_y, w_perim;
    logic [PIX_W-1:0]   w_col;

    assign w_cb       = vid.pixel_in[CB_OFS +: 8];
    assign w_cr       = vid.pixel_in[CR_OFS +: 8];
    assign w_unused_y = ^vid.pixel_in[Y_OFS +: 8];
    assign w_mask     = vid.de_in & in_range(w_cb, CB_MIN, CB_MAX)
                                  & in_range(w_cr, CR_MIN, CR_MAX);

    // r_de1/r_vs1 double as the one-cycle history for edge detection.
    assign w_boundary = vid.vsync_in & ~r_vs1;
    assign w_de_fall  = ~vid.de_in & r_de1;

    assign w_x     = w_boundary ? '0 : r_x;
    assign w_y     = w_boundary ? '0 : r_y;
    assign w_x_inc = (w_x == COORD_MAX) ? w_x : w_x + COORD_W'(1);
    assign w_y_inc = (r_y == COORD_MAX) ? r_y : r_y + COORD_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            if (vid.de_in)                    r_x <= w_x_inc;
            else if (w_boundary || w_de_fall) r_x <= '0;

            if (w_boundary)     r_y <= '0;
            else if (w_de_fall) r_y <= w_y_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de1   <= 1'b0;
            r_hs1   <= 1'b0;
            r_vs1   <= 1'b0;
            r_mask1 <= 1'b0;
            r_x1    <= '0;
            r_y1    <= '0;
        end else begin
            r_de1   <= vid.de_in;
            r_hs1   <= vid.hsync_in;
            r_vs1   <= vid.vsync_in;
            r_mask1 <= w_mask;
            r_x1    <= w_x;
            r_y1    <= w_y;
        end
    end

    bbox_accum #(
        .COORD_W (COORD_W),
        .CNT_W   (CNT_W),
        .MIN_PIX (MIN_PIX)
    ) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_boundary (w_boundary),
        .i_mask     (w_mask),
        .i_x        (w_x),
        .i_y        (w_y),
        .o_xmin     (bbox_xmin),
        .o_xmax     (bbox_xmax),
        .o_ymin     (bbox_ymin),
        .o_ymax     (bbox_ymax),
        .o_count    (bbox_count),
        .o_valid    (bbox_valid)
    );

    assign w_in_x  = (r_x1 >= bbox_xmin) && (r_x1 <= bbox_xmax);
    assign w_in_y  = (r_y1 >= bbox_ymin) && (r_y1 <= bbox_ymax);
    assign w_perim = bbox_valid &&
                     ((((r_x1 == bbox_xmin) || (r_x1 == bbox_xmax)) && w_in_y) ||
                      (((r_y1 == bbox_ymin) || (r_y1 == bbox_ymax)) && w_in_x));

    always_comb begin
        w_col = COL_BLACK;
        if (!r_de1)       w_col = COL_BLACK;
        else if (w_perim) w_col = COL_RED;
        else if (r_mask1) w_col = COL_WHITE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de2  <= 1'b0;
            r_hs2  <= 1'b0;
            r_vs2  <= 1'b0;
            r_pix2 <= COL_BLACK;
        end else begin
            r_de2  <= r_de1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_pix2 <= w_col;
        end
    end

    assign vid.de_out    = r_de2;
    assign vid.hsync_out = r_hs2;
    assign vid.vsync_out = r_vs2;
    assign vid.pixel_out = r_pix2;

endmodule
